// File: rtl/inst_align_queue.sv
// Halfword-granular instruction buffer between ifetch and decoder: splits fetch words
// into 16-bit (RVC) and 32-bit instructions, including ones that straddle two words.
module inst_align_queue #(
   parameter int DEPTH_BIT = 3,
   parameter bit C_EXT     = 1'b1
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        fetch_valid,
   input  logic [31:0] fetch_pc,
   input  logic [31:0] fetch_data,
   output logic        fetch_ready,
   output logic        out_valid,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst,
   output logic        out_is_c,
   input  logic        out_ready,
   input  logic        redirect,
   input  logic        flush
);

   localparam int SIZE = 1 << DEPTH_BIT;
   localparam logic [DEPTH_BIT:0]   CNT_ONE   = (DEPTH_BIT+1)'(1);
   localparam logic [DEPTH_BIT:0]   CNT_TWO   = (DEPTH_BIT+1)'(2);
   localparam logic [DEPTH_BIT:0]   READY_MAX = (DEPTH_BIT+1)'(SIZE - 2);
   localparam logic [DEPTH_BIT-1:0] PTR_ONE   = DEPTH_BIT'(1);
   localparam logic [DEPTH_BIT-1:0] PTR_TWO   = DEPTH_BIT'(2);

   logic [15:0]          mem [SIZE];
   logic [DEPTH_BIT-1:0] head, tail;
   logic [DEPTH_BIT:0]   count;
   logic [31:0]          head_pc;

   logic [15:0]          hw0, hw1;
   logic                 empty, pc_match, push, push_half, pop, clear;
   logic [DEPTH_BIT:0]   push_amt, pop_amt;
   logic [31:0]          expect_pc;

   // Masking with count keeps stale array contents off the outputs.
   assign empty     = (count == '0);
   assign hw0       = empty ? 16'h0 : mem[head];
   assign hw1       = (count >= CNT_TWO) ? mem[head + PTR_ONE] : 16'h0;
   assign out_is_c  = C_EXT && !empty && (hw0[1:0] != 2'b11);
   assign out_valid = out_is_c || (count >= CNT_TWO);
   assign out_inst  = out_is_c ? {16'h0, hw0} : {hw1, hw0};
   assign out_pc    = head_pc;
   assign fetch_ready = (count <= READY_MAX);

   assign expect_pc = head_pc + {{(30-DEPTH_BIT){1'b0}}, count, 1'b0};

   // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      pc_match  = 1'b0;
      push_half = 1'b0;
      if (empty) begin
         pc_match  = C_EXT || !fetch_pc[1];
         push_half = C_EXT && fetch_pc[1];
      end else begin
         pc_match  = (fetch_pc == expect_pc) && (C_EXT || !fetch_pc[1]);
      end
   end

   assign push     = rdy_in && fetch_valid && fetch_ready && pc_match;
   assign pop      = rdy_in && out_valid && out_ready;
   assign clear    = rdy_in && (flush || (redirect && pop));
   assign push_amt = !push ? '0 : (push_half ? CNT_ONE : CNT_TWO);
   assign pop_amt  = !pop  ? '0 : (out_is_c  ? CNT_ONE : CNT_TWO);

   // NOTE: non-blocking assignments for all registered state so every reader sees pre-edge values.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         head_pc <= '0;
      end else if (clear) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         count <= count + push_amt - pop_amt;
         if (push)
            tail <= tail + (push_half ? PTR_ONE : PTR_TWO);
         if (pop) begin
            head    <= head + (out_is_c ? PTR_ONE : PTR_TWO);
            head_pc <= head_pc + (out_is_c ? 32'd2 : 32'd4);
         end else if (push && empty) begin
            head_pc <= fetch_pc;
         end
      end
   end

   // NOTE: the halfword array has no reset; it is only ever read through the count mask.
   always_ff @(posedge clk_in) begin
      if (push && !clear) begin
         if (push_half) begin
            mem[tail] <= fetch_data[31:16];
         end else begin
            mem[tail]           <= fetch_data[15:0];
            mem[tail + PTR_ONE] <= fetch_data[31:16];
         end
      end
   end

endmodule

// File: tb/tb_inst_align_queue.sv
// Directed self-checking bench for inst_align_queue (DEPTH_BIT=3, C_EXT=1).
module tb_inst_align_queue;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic        fetch_valid;
   logic [31:0] fetch_pc;
   logic [31:0] fetch_data;
   logic        fetch_ready;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        out_is_c;
   logic        out_ready;
   logic        redirect;
   logic        flush;

   int checks = 0;
   int errors = 0;

   inst_align_queue #(.DEPTH_BIT(3), .C_EXT(1'b1)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_data(fetch_data),
      .fetch_ready(fetch_ready), .out_valid(out_valid), .out_pc(out_pc),
      .out_inst(out_inst), .out_is_c(out_is_c), .out_ready(out_ready),
      .redirect(redirect), .flush(flush)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic offer(input logic [31:0] pc, input logic [31:0] data);
      fetch_valid = 1'b1;
      fetch_pc    = pc;
      fetch_data  = data;
   endtask

   task automatic quiet();
      fetch_valid = 1'b0;
      fetch_pc    = '0;
      fetch_data  = '0;
      out_ready   = 1'b0;
      redirect    = 1'b0;
      flush       = 1'b0;
      rdy_in      = 1'b1;
   endtask

   task automatic head_is(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                          input logic is_c);
      check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
      check({tag, "_pc"},    out_pc,   pc);
      check({tag, "_inst"},  out_inst, inst);
      check({tag, "_is_c"},  {31'b0, out_is_c}, {31'b0, is_c});
   endtask

   initial begin
      quiet();
      rst_in = 1'b1;
      #3;
      check("rst_valid", {31'b0, out_valid}, 32'd0);
      check("rst_is_c",  {31'b0, out_is_c},  32'd0);
      check("rst_pc",    out_pc,   32'h0);
      check("rst_inst",  out_inst, 32'h0);
      check("rst_ready", {31'b0, fetch_ready}, 32'd1);
      @(posedge clk_in);
      #1 rst_in = 1'b0;

      // Single aligned 32-bit instruction.
      offer(32'h1000, 32'h00A00093);
      tick(); quiet();
      head_is("t1", 32'h1000, 32'h00A00093, 1'b0);
      out_ready = 1'b1;
      tick(); quiet();
      check("t1_empty", {31'b0, out_valid}, 32'd0);
      check("t1_ready", {31'b0, fetch_ready}, 32'd1);

      // Two RVC instructions from one word.
      offer(32'h2000, 32'h45014585);
      out_ready = 1'b1;
      tick(); fetch_valid = 1'b0;
      head_is("t2a", 32'h2000, 32'h00004585, 1'b1);
      tick();
      head_is("t2b", 32'h2002, 32'h00004501, 1'b1);
      tick(); quiet();
      check("t2_empty", {31'b0, out_valid}, 32'd0);

      // Straddling 32-bit instruction.
      offer(32'h3000, 32'h00934501);
      out_ready = 1'b1;
      tick(); fetch_valid = 1'b0;
      head_is("t3a", 32'h3000, 32'h00004501, 1'b1);
      tick();
      check("t3_wait_valid", {31'b0, out_valid}, 32'd0);
      check("t3_wait_pc", out_pc, 32'h3002);
      offer(32'h3004, 32'hBEEF0A00);
      tick(); quiet();
      head_is("t3b", 32'h3002, 32'h0A000093, 1'b0);
      flush = 1'b1;
      tick(); quiet();
      check("t3_flush_valid", {31'b0, out_valid}, 32'd0);

      // Backpressure and pointer wrap.
      for (int i = 0; i < 4; i++) begin
         offer(32'h6000 + 32'(i) * 4, 32'h00100013 + (32'(i) << 20));
         tick();
      end
      check("bp_full_ready", {31'b0, fetch_ready}, 32'd0);
      offer(32'h6010, 32'h00500013);
      tick();
      check("bp_drop_ready", {31'b0, fetch_ready}, 32'd0);
      head_is("bp_head", 32'h6000, 32'h00100013, 1'b0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp_pop_ready", {31'b0, fetch_ready}, 32'd1);
      head_is("bp_pop", 32'h6004, 32'h00200013, 1'b0);
      tick(); quiet();
      check("bp_refill_ready", {31'b0, fetch_ready}, 32'd0);
      out_ready = 1'b1;
      for (int i = 2; i < 5; i++) begin
         tick();
         head_is("bp_drain", 32'h6000 + 32'(i) * 4, 32'h00100013 + (32'(i) << 20), 1'b0);
      end
      tick(); quiet();
      check("bp_empty", {31'b0, out_valid}, 32'd0);

      // Flush beats a same-cycle push and pop.
      offer(32'h7000, 32'h00700013);
      tick(); quiet();
      offer(32'h7004, 32'h00800013);
      out_ready = 1'b1;
      flush     = 1'b1;
      tick(); quiet();
      check("fl_valid", {31'b0, out_valid}, 32'd0);
      check("fl_ready", {31'b0, fetch_ready}, 32'd1);
      check("fl_pc_hold", out_pc, 32'h7000);
      offer(32'h7100, 32'h00900013);
      tick(); quiet();
      head_is("fl_next", 32'h7100, 32'h00900013, 1'b0);
      flush = 1'b1;
      tick(); quiet();

      // Unaligned start, redirect with and without a pop.
      offer(32'h4002, 32'h4505DEAD);
      tick(); quiet();
      head_is("ua_head", 32'h4002, 32'h00004505, 1'b1);
      offer(32'h4004, 32'h00A00093);
      tick(); quiet();
      redirect = 1'b1;
      tick(); quiet();
      head_is("rd_nopop", 32'h4002, 32'h00004505, 1'b1);
      redirect  = 1'b1;
      out_ready = 1'b1;
      offer(32'h4008, 32'h00B00093);
      tick(); quiet();
      check("rd_valid", {31'b0, out_valid}, 32'd0);
      check("rd_ready", {31'b0, fetch_ready}, 32'd1);
      offer(32'h5000, 32'h00C00093);
      tick(); quiet();
      head_is("rd_next", 32'h5000, 32'h00C00093, 1'b0);

      // Non-contiguous word dropped while non-empty.
      offer(32'h5008, 32'h00D00093);
      tick(); quiet();
      out_ready = 1'b1;
      tick(); quiet();
      check("nc_drop", {31'b0, out_valid}, 32'd0);

      // Global enable low freezes everything, including flush.
      offer(32'h8000, 32'h00E00093);
      tick(); quiet();
      rdy_in    = 1'b0;
      out_ready = 1'b1;
      flush     = 1'b1;
      tick(); quiet();
      head_is("rdy_hold", 32'h8000, 32'h00E00093, 1'b0);

      // Asynchronous reset mid-operation.
      #2 rst_in = 1'b1;
      #1;
      check("ar_valid", {31'b0, out_valid}, 32'd0);
      check("ar_pc", out_pc, 32'h0);
      check("ar_ready", {31'b0, fetch_ready}, 32'd1);
      rst_in = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/inst_align_queue.md
# inst_align_queue

Halfword-granular instruction buffer between ifetch and decoder. It accepts 32-bit fetch words at halfword-aligned PCs and splits them into whole 16-bit (RVC) or 32-bit instructions, including 32-bit instructions that straddle two fetch words. It presents one instruction per cycle to the decoder with a valid/ready handshake. It is the buffered, parametrised successor to the decoder's single-word, always-aligned instruction input: depth and RVC support are configurable, and it supports flush and redirect.

## Interface
- `DEPTH_BIT`, default 3: buffer holds 2^DEPTH_BIT halfwords; must be ≥2.
- `C_EXT`, default 1: 1 enables RVC splitting; 0 means every instruction is 32-bit.
- `clk_in` in 1: clock.
- `rst_in` in 1: reset; asynchronous, active-high.
- `rdy_in` in 1: global enable. While low, all state holds; reset still acts.
- `fetch_valid` in 1: fetch word offered.
- `fetch_pc` in 32: PC of `fetch_data[15:0]`; bit 0 is always 0.
- `fetch_data` in 32: fetched word, little-endian halfwords.
- `fetch_ready` out 1: at least 2 free halfword slots.
- `out_valid` out 1: a complete instruction is at the head.
- `out_pc` out 32: PC of the head instruction.
- `out_inst` out 32: the instruction; for RVC, `{16'b0, hw}`.
- `out_is_c` out 1: head instruction is 16-bit.
- `out_ready` in 1: decoder accepts the head (driven by decoder `to_rob`).
- `redirect` in 1: decoder predicted a control transfer on the accepted instruction; discard the remainder of the buffer.
- `flush` in 1: ROB misprediction; discard everything.

## Operation
State:
- Circular halfword array with `head`/`tail` pointers (DEPTH_BIT bits, natural wrap).
- `count` (DEPTH_BIT+1 bits).
- `head_pc` (32 bits).

Push (`fetch_valid && fetch_ready`):
- Buffer empty and `fetch_pc[1]==0`: write both halfwords; `count += 2`; `head_pc <= fetch_pc`.
- Buffer empty and `fetch_pc[1]==1` (C_EXT=1 only): write `fetch_data[31:16]` only; `count += 1`; `head_pc <= fetch_pc`.
- Buffer non-empty: `fetch_pc` must equal `head_pc + 2*count`. Otherwise the word is dropped and no state changes. On match, write both halfwords; `count += 2`.
- With C_EXT=0, a word with `fetch_pc[1]==1` is dropped.

Head decode:
- `hw0` is the halfword at `head`; `hw1` is the halfword at `head+1` (wrapped).
- `out_is_c = C_EXT && hw0[1:0] != 2'b11`.
- `out_valid = (out_is_c && count≥1) || (!out_is_c && count≥2)`.
- `out_inst` is `{hw1, hw0}` or `{16'b0, hw0}`; `out_pc = head_pc`.

Pop (`out_valid && out_ready`):
- `head += 1` or `2`.
- `head_pc += 2` or `4`.
- `count` decrements by the same amount, net of any same-cycle push.

Flush, redirect and ready:
- `redirect` together with a pop: `count`, `head`, `tail` reset to 0. A same-cycle push is discarded. `redirect` without a pop is ignored.
- `flush` takes priority over everything: `count`, `head`, `tail` reset to 0; pop, redirect and push are all ignored that cycle.
- `fetch_ready = (2^DEPTH_BIT - count) ≥ 2`. It is computed from registered `count` only, never from the same-cycle pop.

## Timing
- Reset values: `count`, `head`, `tail`, `head_pc` = 0; `out_valid` = 0, `out_is_c` = 0, `out_pc` = 0, `out_inst` = 0 (array contents masked when empty); `fetch_ready` = 1.
- All outputs are combinational from registered state only; no input-to-output paths.
- Latency: a word pushed in cycle N is visible on `out_*` in cycle N+1.
- Throughput: one instruction per cycle. A straddling 32-bit instruction appears only once its second halfword is resident.
- Push and pop in the same cycle are both performed; count changes by push amount minus pop amount.
- Full (`count == 2^DEPTH_BIT` or `2^DEPTH_BIT-1`): `fetch_ready` = 0.
- Pointers wrap modulo 2^DEPTH_BIT; a 32-bit instruction may span the wrap point.
- Reset asserted mid-operation clears state immediately (asynchronous); outputs go to reset values without waiting for a clock edge.
- `rdy_in` = 0: no push, no pop, no flush/redirect effect. Outputs still reflect held state.

## Test plan
- Reset, then push `pc=0x1000, data=0x00A00093` (addi, 32-bit) → next cycle `out_valid=1`, `out_pc=0x1000`, `out_inst=0x00A00093`, `out_is_c=0`; after pop, `count=0`.
- Push `pc=0x2000, data=0x45014585` (two RVC) with `out_ready=1` → cycle 1: `0x4585` at `0x2000`; cycle 2: `0x4501` at `0x2002`, `out_is_c=1`.
- Straddle: push `pc=0x3000, data=0x00934501`, then `pc=0x3004, data=0xXXXX0A00` → RVC `0x4501` at `0x3000`; `out_valid=0` until the second word arrives; then `0x0A000093` at `0x3002`.
- Backpressure, DEPTH_BIT=3, `out_ready=0`: push 4 consecutive words → `fetch_ready=0` after the fourth; a 5th offered word is not accepted; one 32-bit pop restores `fetch_ready=1`.
- `flush` asserted in the same cycle as a push and a pop → next cycle `count=0`, `out_valid=0`, `head_pc` unchanged until the next push sets it to that word's `fetch_pc`.
- Unaligned start (`pc=0x4002`, C_EXT=1) sets `head_pc=0x4002`, `count=1`. Then `redirect` with a pop while 3 halfwords are buffered → all discarded. A subsequent non-contiguous `fetch_pc=0x5000` is accepted because the buffer is empty.
